// File: rtl/mor1kx_ram_fifo.sv
// ---------------------------------------------------------------------------
// mor1kx_ram_fifo
//
// Single-clock first-word-fallthrough FIFO. Storage is one array with a
// synchronous write port and a read port driven by a registered address,
// so it maps onto single-clock block RAM. The read address register is
// loaded with the read pointer the FIFO will have after this edge. The head
// entry is therefore on data_o one cycle after any push or pop, with no
// extra bubble.
//
// Ports:
//   clk      in   single clock, all state updates on rising edge
//   rst      in   asynchronous active-high reset (empties the FIFO)
//   flush_i  in   synchronous clear; overrides push and pop
//   write_i  in   push request, accepted when not full
//   data_i   in   push data
//   read_i   in   pop request, accepted when not empty
//   data_o   out  head entry (meaningless while empty_o=1)
//   full_o   out  DEPTH entries held
//   empty_o  out  no entries held
//   count_o  out  number of entries held, 0..DEPTH
// ---------------------------------------------------------------------------
module mor1kx_ram_fifo #(
    parameter int DEPTH_WIDTH = 4,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   write_i,
    input  logic [DATA_WIDTH-1:0]  data_i,
    input  logic                   read_i,
    output logic [DATA_WIDTH-1:0]  data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [DEPTH_WIDTH:0]   count_o
);

    localparam int DEPTH = 2 ** DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] PTR_ONE = (DEPTH_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
    logic [DEPTH_WIDTH:0]   r_wptr;
    logic [DEPTH_WIDTH:0]   r_rptr;
    logic [DEPTH_WIDTH-1:0] r_rd_addr;
    logic [DEPTH_WIDTH:0]   w_rptr_next;
    logic                   w_push;
    logic                   w_pop;

    // The pointers carry one extra wrap bit. Equal pointers mean empty.
    // Equal index bits with different wrap bits mean full.
    assign empty_o = (r_wptr == r_rptr);
    assign full_o  = (r_wptr[DEPTH_WIDTH-1:0] == r_rptr[DEPTH_WIDTH-1:0]) &&
                     (r_wptr[DEPTH_WIDTH] != r_rptr[DEPTH_WIDTH]);
    assign count_o = r_wptr - r_rptr;

    // A push while full is dropped even if a pop is accepted in the same cycle.
    assign w_push = write_i & ~full_o;
    assign w_pop  = read_i & ~empty_o;

    // NOTE: every variable written in always_comb receives a default first,
    // so that no path through the block can infer a latch.
    always_comb begin
        w_rptr_next = r_rptr;
        if (w_pop) begin
            w_rptr_next = r_rptr + PTR_ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register here therefore samples pre-edge values, whatever the
    // statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_rd_addr <= '0;
        end else if (flush_i) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_rd_addr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            r_rptr    <= w_rptr_next;
            r_rd_addr <= w_rptr_next[DEPTH_WIDTH-1:0];
        end
    end

    // NOTE: the storage array has no reset. The contents are meaningless
    // until written, and a reset would prevent mapping onto block RAM.
    always_ff @(posedge clk) begin
        if (w_push && !flush_i) begin
            r_mem[r_wptr[DEPTH_WIDTH-1:0]] <= data_i;
        end
    end

    // The read address is registered, so a write and a read of the same
    // index at one edge give the new word on the next cycle (write-first).
    assign data_o = r_mem[r_rd_addr];

endmodule

// File: tb/tb_mor1kx_ram_fifo.sv
// ---------------------------------------------------------------------------
// tb_mor1kx_ram_fifo
//
// Self-checking bench for mor1kx_ram_fifo (DEPTH_WIDTH=4, DATA_WIDTH=32).
// The reference model is a queue of words: pushes append and pops remove
// from the front, flushes and resets clear it. Outputs are sampled on the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_mor1kx_ram_fifo;

    localparam int DW    = 4;
    localparam int WIDTH = 32;
    localparam int DEPTH = 2 ** DW;

    logic             clk;
    logic             rst;
    logic             flush_i;
    logic             write_i;
    logic [WIDTH-1:0] data_i;
    logic             read_i;
    logic [WIDTH-1:0] data_o;
    logic             full_o;
    logic             empty_o;
    logic [DW:0]      count_o;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] q[$];

    mor1kx_ram_fifo #(
        .DEPTH_WIDTH(DW),
        .DATA_WIDTH (WIDTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .flush_i(flush_i),
        .write_i(write_i),
        .data_i (data_i),
        .read_i (read_i),
        .data_o (data_o),
        .full_o (full_o),
        .empty_o(empty_o),
        .count_o(count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle of requests from a falling edge and updates the model
    // at the rising edge. It then returns at the next falling edge with the
    // requests cleared.
    task automatic cycle(input logic w, input logic [WIDTH-1:0] d,
                         input logic r, input logic f);
        bit do_pop;
        bit do_push;
        write_i = w;
        data_i  = d;
        read_i  = r;
        flush_i = f;
        @(posedge clk);
        if (f) begin
            q.delete();
        end else begin
            do_pop  = r && (q.size() != 0);
            do_push = w && (q.size() < DEPTH);
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(d);
        end
        @(negedge clk);
        write_i = 1'b0;
        read_i  = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        flush_i = 1'b0;
        write_i = 1'b0;
        read_i  = 1'b0;
        data_i  = '0;
        #1;
        checks++;
        if (empty_o !== 1'b1 || full_o !== 1'b0 || count_o !== '0) begin
            failures++;
            $display("FAIL reset_flags empty=%b full=%b count=%0d required empty=1 full=0 count=0",
                     empty_o, full_o, count_o);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
    endtask

    task automatic test_push_empty();
        cycle(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
        checks++;
        if (empty_o !== 1'b0 || count_o !== 5'd1 || data_o !== 32'hA5A5_A5A5) begin
            failures++;
            $display("FAIL push_empty empty=%b count=%0d data=%h required empty=0 count=1 data=a5a5a5a5",
                     empty_o, count_o, data_o);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (empty_o !== 1'b1 || count_o !== '0) begin
            failures++;
            $display("FAIL pop_to_empty empty=%b count=%0d required empty=1 count=0", empty_o, count_o);
        end
    endtask

    task automatic test_fill_full();
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, WIDTH'(i), 1'b0, 1'b0);
        checks++;
        if (full_o !== 1'b1 || count_o !== 5'd16 || data_o !== 32'd1) begin
            failures++;
            $display("FAIL fill_full full=%b count=%0d data=%h required full=1 count=16 data=1",
                     full_o, count_o, data_o);
        end
        cycle(1'b1, 32'hFF, 1'b0, 1'b0);
        checks++;
        if (count_o !== 5'd16 || data_o !== 32'd1) begin
            failures++;
            $display("FAIL push_while_full count=%0d data=%h required count=16 data=1", count_o, data_o);
        end
        cycle(1'b1, 32'hFF, 1'b1, 1'b0);
        checks++;
        if (full_o !== 1'b0 || count_o !== 5'd15 || data_o !== 32'd2) begin
            failures++;
            $display("FAIL full_push_pop full=%b count=%0d data=%h required full=0 count=15 data=2",
                     full_o, count_o, data_o);
        end
        checks++;
        if (q[q.size()-1] !== 32'd16) begin
            failures++;
            $display("FAIL full_drop_model tail=%h required 10", q[q.size()-1]);
        end
    endtask

    task automatic test_drain();
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, WIDTH'(i), 1'b0, 1'b0);
        for (int i = 1; i <= DEPTH; i++) begin
            checks++;
            if (data_o !== WIDTH'(i) || count_o !== (DW+1)'(DEPTH - i + 1)) begin
                failures++;
                $display("FAIL drain_order[%0d] data=%h count=%0d required data=%h count=%0d",
                         i, data_o, count_o, WIDTH'(i), DEPTH - i + 1);
            end
            cycle(1'b0, '0, 1'b1, 1'b0);
        end
        checks++;
        if (empty_o !== 1'b1 || count_o !== '0) begin
            failures++;
            $display("FAIL drain_empty empty=%b count=%0d required empty=1 count=0", empty_o, count_o);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (empty_o !== 1'b1 || count_o !== '0 || full_o !== 1'b0) begin
            failures++;
            $display("FAIL extra_read empty=%b full=%b count=%0d required empty=1 full=0 count=0",
                     empty_o, full_o, count_o);
        end
    endtask

    task automatic test_simul_push_pop();
        cycle(1'b1, 32'h11, 1'b0, 1'b0);
        cycle(1'b1, 32'h22, 1'b1, 1'b0);
        checks++;
        if (count_o !== 5'd1 || empty_o !== 1'b0 || data_o !== 32'h22) begin
            failures++;
            $display("FAIL simul_count1 count=%0d empty=%b data=%h required count=1 empty=0 data=22",
                     count_o, empty_o, data_o);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        int pushes;
        int pops;
        int budget;
        bit w;
        bit r;
        bit bias;
        pushes = 0;
        pops   = 0;
        budget = 0;
        while ((pushes < 40 || q.size() != 0) && budget < 600) begin
            // Swap between filling and draining phases so that occupancy
            // moves over the whole range, including full and empty.
            if ((budget % 24) == 0) bias = $urandom_range(0, 1) == 1;
            if (pushes >= 40) begin
                w = 1'b0;
                r = 1'b1;
            end else begin
                w = bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                r = bias ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            end
            if (w && q.size() < DEPTH) pushes++;
            if (r && q.size() != 0) pops++;
            cycle(w, $urandom, r, 1'b0);
            checks++;
            if (count_o !== (DW+1)'(q.size()) || empty_o !== (q.size() == 0) ||
                full_o !== (q.size() == DEPTH) ||
                (q.size() != 0 && data_o !== q[0])) begin
                failures++;
                $display("FAIL random_step[%0d] count=%0d empty=%b full=%b data=%h required count=%0d head=%h",
                         budget, count_o, empty_o, full_o, data_o, q.size(),
                         (q.size() != 0) ? q[0] : '0);
            end
            budget++;
        end
        checks++;
        if (pushes < 40 || pops != pushes) begin
            failures++;
            $display("FAIL random_budget pushes=%0d pops=%0d required 40 pushes fully drained", pushes, pops);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h100 + WIDTH'(i), 1'b0, 1'b0);
        checks++;
        if (count_o !== 5'd5) begin
            failures++;
            $display("FAIL flush_prefill count=%0d required 5", count_o);
        end
        cycle(1'b1, 32'hDEAD, 1'b1, 1'b1);
        checks++;
        if (empty_o !== 1'b1 || count_o !== '0) begin
            failures++;
            $display("FAIL flush_priority empty=%b count=%0d required empty=1 count=0", empty_o, count_o);
        end
        cycle(1'b1, 32'h77, 1'b0, 1'b0);
        checks++;
        if (count_o !== 5'd1 || data_o !== 32'h77) begin
            failures++;
            $display("FAIL after_flush count=%0d data=%h required count=1 data=77", count_o, data_o);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h200 + WIDTH'(i), 1'b0, 1'b0);
        write_i = 1'b1;
        data_i  = 32'h300;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (empty_o !== 1'b1 || full_o !== 1'b0 || count_o !== '0) begin
            failures++;
            $display("FAIL async_reset empty=%b full=%b count=%0d required empty=1 full=0 count=0",
                     empty_o, full_o, count_o);
        end
        q.delete();
        read_i = 1'b1;
        @(negedge clk);
        checks++;
        if (empty_o !== 1'b1 || count_o !== '0) begin
            failures++;
            $display("FAIL req_during_reset empty=%b count=%0d required empty=1 count=0", empty_o, count_o);
        end
        write_i = 1'b0;
        read_i  = 1'b0;
        rst     = 1'b0;
        @(negedge clk);
        cycle(1'b1, 32'h5A5A_0001, 1'b0, 1'b0);
        checks++;
        if (empty_o !== 1'b0 || count_o !== 5'd1 || data_o !== 32'h5A5A_0001) begin
            failures++;
            $display("FAIL push_after_reset empty=%b count=%0d data=%h required empty=0 count=1 data=5a5a0001",
                     empty_o, count_o, data_o);
        end
    endtask

    initial begin
        test_reset();
        test_push_empty();
        test_fill_full();
        test_drain();
        test_simul_push_pop();
        test_random();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
